// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHdrHi,
    StHdrLo,
    StData,
    StDone
  } state_e;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned ADDR_SHIFT     = 2;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs a big-endian byte stream into 32-bit words; word_valid pulses combinationally
// on the byte that completes a word, alongside the assembled word.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  in_data,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  idx_q;
  logic [23:0] shreg_q;

  // The incoming byte is always the least significant byte of the candidate word.
  assign word       = {shreg_q, in_data};
  assign word_valid = shift_en && (idx_q == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q   <= 2'd0;
      shreg_q <= 24'd0;
    end else if (clear) begin
      idx_q   <= 2'd0;
      shreg_q <= 24'd0;
    end else if (shift_en) begin
      idx_q   <= idx_q + 2'd1;
      shreg_q <= word[23:0];
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader: header of word count, then big-endian words written to
// sequential word-aligned addresses from 0, holding the CPU while the load runs.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH = 51,
  parameter int unsigned CNT_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        we,
  output logic [31:0] waddr,
  output logic [31:0] wdata,
  output logic        busy,
  output logic        hold_cpu,
  output logic        done,
  output logic        err
);

  state_e             state_q, state_d;
  logic [7:0]         count_hi_q;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   word_idx_q;
  logic               we_q, busy_q, done_q, err_q;
  logic [31:0]        waddr_q, wdata_q;

  logic               accept;
  logic [CNT_W-1:0]   full_count;
  logic               last_word;
  logic               pack_clear, pack_shift;
  logic [31:0]        pack_word;
  logic               word_valid;

  assign accept     = in_valid && in_ready;
  assign full_count = CNT_W'({count_hi_q, in_data});
  assign last_word  = (word_idx_q == count_q - CNT_W'(1));
  assign pack_clear = start && (state_q == StIdle);
  assign pack_shift = accept && (state_q == StData);

  byte_packer u_byte_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (pack_clear),
    .shift_en   (pack_shift),
    .in_data    (in_data),
    .word       (pack_word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StHdrHi;
      StHdrHi: if (accept) state_d = StHdrLo;
      StHdrLo: begin
        if (accept) begin
          if (full_count == '0) begin
            state_d = StDone;
          end else if (full_count > CNT_W'(DEPTH)) begin
            state_d = StIdle;
          end else begin
            state_d = StData;
          end
        end
      end
      StData:  if (word_valid && last_word) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready = (state_q == StHdrHi) || (state_q == StHdrLo) || (state_q == StData);
    hold_cpu = (state_q != StIdle);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_hi_q <= 8'd0;
      count_q    <= '0;
      word_idx_q <= '0;
      we_q       <= 1'b0;
      waddr_q    <= 32'd0;
      wdata_q    <= 32'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // Registered outputs look one state ahead so they line up with the state itself.
      busy_q <= (state_d != StIdle);
      done_q <= (state_d == StDone);
      we_q   <= word_valid;
      if (word_valid) begin
        wdata_q    <= pack_word;
        waddr_q    <= 32'(word_idx_q) << ADDR_SHIFT;
        word_idx_q <= word_idx_q + CNT_W'(1);
      end
      if (pack_clear) begin
        err_q      <= 1'b0;
        word_idx_q <= '0;
      end
      if (accept && (state_q == StHdrHi)) begin
        count_hi_q <= in_data;
      end
      if (accept && (state_q == StHdrLo)) begin
        count_q <= full_count;
        if (full_count > CNT_W'(DEPTH)) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign we    = we_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus queues expected writes/done events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready, we, busy, hold_cpu, done, err;
  logic [31:0] waddr, wdata;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_wq[$];
  bit          exp_dq[$];
  logic [7:0]  tx_q[$];
  int          start_at = -1;
  int          n_checks = 0;
  int          n_pass = 0;
  int          n_writes = 0;
  logic [31:0] last_waddr = 32'd0;
  logic        prev_we = 1'b0;

  imem_loader #(.DEPTH(51), .CNT_W(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .busy     (busy),
    .hold_cpu (hold_cpu),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: every write and done pulse must match the head of its queue.
  always @(negedge clk) begin
    if (reset) begin
      prev_we = 1'b0;
    end else begin
      if (we) begin
        chk("we_back_to_back", prev_we, 0);
        chk("we_expected", exp_wq.size() > 0, 1);
        if (exp_wq.size() > 0) begin
          wr_t e;
          e = exp_wq.pop_front();
          chk("waddr", waddr, e.addr);
          chk("wdata", wdata, e.data);
        end
        n_writes++;
        last_waddr = waddr;
      end
      prev_we = we;
      if (done) begin
        chk("done_expected", exp_dq.size() > 0, 1);
        if (exp_dq.size() > 0) chk("done_with_we", we, exp_dq.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Streams tx_q back-to-back; optional start pulse alongside byte index start_at.
  task automatic stream();
    int i = 0;
    while (tx_q.size() > 0) begin
      int budget = 0;
      in_valid = 1'b1;
      in_data  = tx_q[0];
      start    = (i == start_at);
      @(negedge clk);
      while (!in_ready && budget < 50) begin
        budget++;
        @(negedge clk);
      end
      if (!in_ready) begin
        chk("in_ready_timeout", in_ready, 1);
        tx_q.delete();
      end else begin
        @(posedge clk); #1;
        void'(tx_q.pop_front());
        i++;
      end
    end
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] addr, input logic [31:0] data);
    exp_wq.push_back('{addr: addr, data: data});
    tx_q.push_back(data[31:24]);
    tx_q.push_back(data[23:16]);
    tx_q.push_back(data[15:8]);
    tx_q.push_back(data[7:0]);
  endtask

  task automatic push_hdr(input logic [15:0] cnt);
    tx_q.push_back(cnt[15:8]);
    tx_q.push_back(cnt[7:0]);
  endtask

  task automatic settle(input string tag);
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_writes_drained"}, exp_wq.size(), 0);
    chk({tag, "_done_drained"}, exp_dq.size(), 0);
    chk({tag, "_idle_busy"}, busy, 0);
  endtask

  initial begin
    #3 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_flags", {in_ready, we, busy, hold_cpu, done, err}, 6'b0);
    chk("reset_waddr", waddr, 0);
    chk("reset_wdata", wdata, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_in_ready", in_ready, 0);

    // Basic two-word load.
    do_start();
    chk("start_in_ready", in_ready, 1);
    chk("start_hold_cpu", hold_cpu, 1);
    push_hdr(16'd2);
    push_word(32'd0, 32'h2008_0005);
    push_word(32'd4, 32'h0109_5020);
    exp_dq.push_back(1'b1);
    stream();
    chk("basic_busy_in_done", busy, 1);
    @(posedge clk); #1;
    chk("basic_busy_falls", busy, 0);
    settle("basic");

    // Empty program.
    do_start();
    push_hdr(16'd0);
    exp_dq.push_back(1'b0);
    stream();
    chk("empty_done", done, 1);
    chk("empty_err", err, 0);
    settle("empty");

    // Oversize header, then recovery.
    do_start();
    push_hdr(16'd52);
    stream();
    chk("oversize_err", err, 1);
    chk("oversize_idle", {busy, in_ready}, 2'b00);
    settle("oversize");
    chk("oversize_err_sticky", err, 1);
    do_start();
    chk("restart_clears_err", err, 0);
    push_hdr(16'd1);
    push_word(32'd0, 32'hDEAD_BEEF);
    exp_dq.push_back(1'b1);
    stream();
    settle("recover");

    // Back-pressure mid-word.
    do_start();
    push_hdr(16'd1);
    exp_wq.push_back('{addr: 32'd0, data: 32'hAABB_CCDD});
    exp_dq.push_back(1'b1);
    tx_q.push_back(8'hAA);
    tx_q.push_back(8'hBB);
    stream();
    repeat (5) @(posedge clk);
    #1;
    chk("stall_no_we_yet", exp_wq.size(), 1);
    tx_q.push_back(8'hCC);
    tx_q.push_back(8'hDD);
    stream();
    settle("stall");

    // Reset after six bytes of a three-word load.
    do_start();
    push_hdr(16'd3);
    exp_wq.push_back('{addr: 32'd0, data: 32'h1122_3344});
    tx_q.push_back(8'h11); tx_q.push_back(8'h22);
    tx_q.push_back(8'h33); tx_q.push_back(8'h44);
    stream();
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    chk("async_rst_flags", {in_ready, we, busy, hold_cpu, done, err}, 6'b0);
    chk("async_rst_waddr", waddr, 0);
    chk("async_rst_wdata", wdata, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    do_start();
    push_hdr(16'd1);
    push_word(32'd0, 32'hCAFE_F00D);
    exp_dq.push_back(1'b1);
    stream();
    settle("after_reset");

    // Full-depth load with a start pulse while in DATA.
    n_writes = 0;
    do_start();
    push_hdr(16'd51);
    for (int i = 0; i < 51; i++) begin
      logic [7:0] b0, b1, b2, b3;
      b0 = 8'(i);
      b1 = 8'h3C;
      b2 = 8'(255 - i);
      b3 = 8'(i * 3);
      push_word(32'(i * 4), {b0, b1, b2, b3});
    end
    exp_dq.push_back(1'b1);
    start_at = 40;
    stream();
    start_at = -1;
    settle("full");
    chk("full_write_count", n_writes, 51);
    chk("full_last_waddr", last_waddr, 200);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
